data_mem_be: RTL and testbench
==============================

// Module: data_mem_be
// PURPOSE
//  Parametrised successor data memory for the CPU load/store stage: byte/halfword/word
//  access with little-endian lane selection, sign/zero-extended loads and alignment checking.
//  A hardware clear sequencer zeroes the array after reset. One write port and one read port,
//  1-cycle registered read. Sits between the execute/memory pipeline stage and writeback.
// PARAMETERS
//  SIZE      4096  memory size in bytes; multiple of 4, power of two; WORDS = SIZE/4
//  ADDR_W    32    width of byte addresses; only bits [log2(SIZE)-1:0] index the array
//  CLEAR_VAL 0     32-bit value written to every word by the clear sequencer
// PORTS
//  clk          in   1       clock, all state on rising edge
//  reset_n      in   1       asynchronous active-low reset
//  ready        out  1       1 = clear finished, accesses accepted
//  write_en     in   1       store request this cycle
//  write_addr   in   ADDR_W  store byte address
//  write_size   in   2       00 byte, 01 halfword, 10 word, 11 illegal
//  write_data   in   32      store data, right-justified (byte in [7:0], half in [15:0])
//  read_en      in   1       load request this cycle
//  read_addr    in   ADDR_W  load byte address
//  read_size    in   2       encoding as write_size
//  read_signed  in   1       1 = sign-extend sub-word load, 0 = zero-extend
//  read_data    out  32      load result, registered
//  read_valid   out  1       1-cycle pulse, read_data valid
//  align_err    out  1       1-cycle pulse, misaligned/illegal access in previous cycle
// BEHAVIOUR
//  - Reset (reset_n=0, async): read_data=0, read_valid=0, align_err=0, ready=0, state=CLEAR,
//    clr_ptr=0. Array contents not touched by reset itself.
//  - FSM CLEAR: each cycle word[clr_ptr]<=CLEAR_VAL, clr_ptr++; after word WORDS-1 -> RUN.
//    ready rises the cycle after the last clear write (WORDS cycles after reset release).
//    read_en/write_en ignored in CLEAR (no write, no read_valid, no align_err).
//    Reset asserted mid-clear restarts at clr_ptr=0.
//  - FSM RUN: stays until reset. ready=1.
//  - Index = addr[log2(SIZE)-1:2]; higher address bits ignored (wrap modulo SIZE).
//  - Alignment: half needs addr[0]=0; word needs addr[1:0]=00; size 11 always illegal.
//  - Store: byte writes lane addr[1:0]; half writes lanes {addr[1],0}+1..+0; word all lanes;
//    other lanes unchanged. Misaligned store suppressed; align_err=1 next cycle.
//  - Load: read_valid=1 next cycle after read_en in RUN. Lane extraction as for store,
//    result extended per read_signed (word ignores it). Misaligned load: read_data=0,
//    read_valid=1, align_err=1. read_data holds value when read_en=0.
//  - Load and store both misaligned same cycle: single align_err pulse.
//  - Same-word read and write in one cycle: see CONFIGURATION.
// CONFIGURATION
//  DMEM_FWD_EN defined: same-word same-cycle load returns word with the store's enabled
//    lanes merged in (write-first), then extended. Suppressed (misaligned) stores not forwarded.
//  DMEM_FWD_EN undefined: same-word load returns pre-store contents (read-first).
// TESTING
//  1 Reset release, SIZE=64: ready=0 for 16 cycles, =1 on 17th; loads of 0x00..0x3C return 0.
//  2 Word store 0xDEADBEEF @0x10; byte load signed @0x11 -> 0xFFFFFFBE; unsigned @0x13
//    -> 0x000000DE; half signed @0x12 -> 0xFFFFDEAD.
//  3 Byte store 0x55 @0x12 over 0xDEADBEEF -> word load @0x10 = 0xDE55BEEF.
//  4 Word store @0x06 and half load @0x03: no write, read_data=0, read_valid=1, align_err=1
//    one cycle only; word @0x04 unchanged.
//  5 Store 0x11223344 and load @0x20 same cycle, old 0xAAAAAAAA: FWD off -> 0xAAAAAAAA,
//    FWD on -> 0x11223344; next load -> 0x11223344 both builds.
//  6 reset_n pulsed low at clear cycle 5: ready drops, clear restarts, ready after 16 more
//    cycles; load @0x40 with SIZE=64 aliases 0x00.

Source files
------------

// File: rtl/data_mem_be.sv
// data_mem_be: byte/half/word data memory with lane selection, load extension,
// alignment checking, post-reset clear sequencer and 1-cycle registered read.
// Optional DMEM_FWD_EN: same-word same-cycle load sees the store (write-first);
// otherwise the load returns the pre-store contents (read-first).
module data_mem_be #(
  parameter int          SIZE      = 4096,
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] CLEAR_VAL = 32'h0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              ready,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [1:0]        write_size,
  input  logic [31:0]       write_data,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic [1:0]        read_size,
  input  logic              read_signed,
  output logic [31:0]       read_data,
  output logic              read_valid,
  output logic              align_err
);
  localparam int WORDS = SIZE / 4;
  localparam int AW    = $clog2(SIZE);
  localparam int IW    = AW - 2;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t        state_q;
  logic [IW-1:0] clr_ptr_q;
  logic          ready_q;
  logic [31:0]   read_data_q, read_data_d;
  logic          read_valid_q;
  logic          align_err_q, align_err_d;
  logic [31:0]   mem_q [WORDS];
  logic          run;
  logic [IW-1:0] w_idx, r_idx;
  logic [1:0]    w_off, r_off;
  logic          w_mis, r_mis, w_do;
  logic [3:0]    w_be;
  logic [31:0]   w_rep, r_raw, r_word, r_shift, r_ext;
  logic          unused_addr;
  function automatic logic misaligned(input logic [1:0] off, input logic [1:0] sz);
    return sz == 2'b11 || (sz == 2'b01 && off[0]) || (sz == 2'b10 && off != 2'b00);
  endfunction
  function automatic logic [3:0] lanes(input logic [1:0] off, input logic [1:0] sz);
    return sz == 2'b00 ? 4'b0001 << off : sz == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
  assign run         = state_q == RUN;
  assign w_idx       = write_addr[AW-1:2];
  assign w_off       = write_addr[1:0];
  assign r_idx       = read_addr[AW-1:2];
  assign r_off       = read_addr[1:0];
  assign unused_addr = ^{write_addr[ADDR_W-1:AW], read_addr[ADDR_W-1:AW]};
  assign w_mis       = misaligned(w_off, write_size);
  assign r_mis       = misaligned(r_off, read_size);
  assign w_be        = lanes(w_off, write_size);
  assign w_rep       = write_size == 2'b00 ? {4{write_data[7:0]}} :
                       write_size == 2'b01 ? {2{write_data[15:0]}} : write_data;
  assign w_do        = run && write_en && !w_mis;
  assign r_raw       = mem_q[r_idx];
`ifdef DMEM_FWD_EN
  // Merge the accepted store's lanes into a same-word load (write-first).
  always_comb begin
    r_word = r_raw;
    for (int b = 0; b < 4; b++)
      if (w_do && w_idx == r_idx && w_be[b]) r_word[8*b +: 8] = w_rep[8*b +: 8];
  end
`else
  assign r_word = r_raw;
`endif
  // Lane extraction and sign/zero extension of the load result.
  always_comb begin
    r_shift     = r_word >> {r_off, 3'b000};
    r_ext       = read_size == 2'b00 ? {{24{read_signed & r_shift[7]}}, r_shift[7:0]} :
                  read_size == 2'b01 ? {{16{read_signed & r_shift[15]}}, r_shift[15:0]} : r_word;
    read_data_d = r_mis ? 32'h0 : r_ext;
    align_err_d = (read_en && r_mis) || (write_en && w_mis);
  end
  // Array: clear sequencer writes while clearing, byte-enabled stores while running.
  always_ff @(posedge clk) begin
    if (!run && reset_n) mem_q[clr_ptr_q] <= CLEAR_VAL;
    else if (w_do)
      for (int b = 0; b < 4; b++)
        if (w_be[b]) mem_q[w_idx][8*b +: 8] <= w_rep[8*b +: 8];
  end
  // Clear/run sequencer with registered load result and status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= CLEAR;
      clr_ptr_q    <= '0;
      ready_q      <= 1'b0;
      read_data_q  <= 32'h0;
      read_valid_q <= 1'b0;
      align_err_q  <= 1'b0;
    end else if (!run) begin
      clr_ptr_q    <= clr_ptr_q + IW'(1);
      read_valid_q <= 1'b0;
      align_err_q  <= 1'b0;
      if (clr_ptr_q == IW'(WORDS - 1)) begin
        state_q <= RUN;
        ready_q <= 1'b1;
      end
    end else begin
      read_valid_q <= read_en;
      align_err_q  <= align_err_d;
      if (read_en) read_data_q <= read_data_d;
    end
  end
  assign ready      = ready_q;
  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign align_err  = align_err_q;
endmodule

// File: tb/tb_data_mem_be.sv
// tb_data_mem_be: directed and randomized checks of data_mem_be (SIZE=64) against a byte-array model.
module tb_data_mem_be;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        ready;
  logic        write_en, read_en, read_signed;
  logic [31:0] write_addr, read_addr, write_data;
  logic [1:0]  write_size, read_size;
  logic [31:0] read_data;
  logic        read_valid, align_err;
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  mb [64];
  logic [31:0] exp_rd = 32'h0;

  always #5 clk = ~clk;

  data_mem_be #(.SIZE(64), .ADDR_W(32), .CLEAR_VAL(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .ready(ready),
    .write_en(write_en), .write_addr(write_addr), .write_size(write_size), .write_data(write_data),
    .read_en(read_en), .read_addr(read_addr), .read_size(read_size), .read_signed(read_signed),
    .read_data(read_data), .read_valid(read_valid), .align_err(align_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic bad(input logic [31:0] a, input logic [1:0] s);
    int n = 1 << s;
    return s == 2'd3 || (a % n) != 0;
  endfunction

  function automatic logic [31:0] mload(input logic [31:0] a, input logic [1:0] s, input logic sg);
    int n = 1 << s;
    logic [31:0] v = 32'h0;
    if (bad(a, s)) return 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(mb[(a + i) % 64]) << (8 * i));
    if (sg && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 1);
    return v;
  endfunction

  task automatic mstore(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    int n = 1 << s;
    if (!bad(a, s))
      for (int i = 0; i < n; i++) mb[(a + i) % 64] = 8'(d >> (8 * i));
  endtask

  task automatic op(input logic we, input logic [31:0] wa, input logic [1:0] ws, input logic [31:0] wd,
                    input logic re, input logic [31:0] ra, input logic [1:0] rs, input logic sg,
                    input string tag);
    logic [31:0] e;
    logic ea;
`ifdef DMEM_FWD_EN
    if (we) mstore(wa, ws, wd);
    e = mload(ra, rs, sg);
`else
    e = mload(ra, rs, sg);
    if (we) mstore(wa, ws, wd);
`endif
    ea = (we && bad(wa, ws)) || (re && bad(ra, rs));
    write_en = we; write_addr = wa; write_size = ws; write_data = wd;
    read_en = re; read_addr = ra; read_size = rs; read_signed = sg;
    @(posedge clk);
    #1;
    if (re) exp_rd = e;
    chk({tag, "/rv"}, 32'(read_valid), 32'(re));
    chk({tag, "/rd"}, read_data, exp_rd);
    chk({tag, "/ae"}, 32'(align_err), 32'(ea));
    write_en = 1'b0;
    read_en = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] s, input logic sg, input string tag);
    op(1'b0, 32'h0, 2'd0, 32'h0, 1'b1, a, s, sg, tag);
  endtask

  task automatic store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d, input string tag);
    op(1'b1, a, s, d, 1'b0, 32'h0, 2'd0, 1'b0, tag);
  endtask

  initial begin
    int n;
    logic we, re, sg;
    logic [1:0] ws, rs;
    logic [31:0] wa, ra;
    reset_n = 1'b0;
    write_en = 1'b0; write_addr = '0; write_size = '0; write_data = '0;
    read_en = 1'b0; read_addr = '0; read_size = '0; read_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/ready", 32'(ready), 32'h0);
    chk("rst/rv", 32'(read_valid), 32'h0);
    chk("rst/ae", 32'(align_err), 32'h0);
    chk("rst/rd", read_data, 32'h0);
    reset_n = 1'b1;
    // Clear phase: accesses (including misaligned ones) must be ignored.
    for (int k = 1; k <= 16; k++) begin
      write_en = 1'b1; write_addr = 32'(4 * (k % 16)); write_size = 2'd2; write_data = 32'hFFFFFFFF;
      read_en = 1'b1; read_addr = 32'h1; read_size = 2'd2;
      @(posedge clk);
      #1;
      chk($sformatf("clr%0d/ready", k), 32'(ready), 32'(k == 16));
      chk($sformatf("clr%0d/rv", k), 32'(read_valid), 32'h0);
      chk($sformatf("clr%0d/ae", k), 32'(align_err), 32'h0);
    end
    write_en = 1'b0; read_en = 1'b0;
    for (int i = 0; i < 64; i++) mb[i] = 8'h0;
    for (int a = 0; a < 64; a += 4) begin
      load(32'(a), 2'd2, 1'b0, $sformatf("t1@%0h", a));
      chk($sformatf("t1k@%0h", a), read_data, 32'h0);
    end
    // Lane selection and extension.
    store(32'h10, 2'd2, 32'hDEADBEEF, "t2/sw");
    load(32'h11, 2'd0, 1'b1, "t2/lb");
    chk("t2/lbk", read_data, 32'hFFFFFFBE);
    load(32'h13, 2'd0, 1'b0, "t2/lbu");
    chk("t2/lbuk", read_data, 32'h000000DE);
    load(32'h12, 2'd1, 1'b1, "t2/lh");
    chk("t2/lhk", read_data, 32'hFFFFDEAD);
    store(32'h12, 2'd0, 32'h00000055, "t3/sb");
    load(32'h10, 2'd2, 1'b0, "t3/lw");
    chk("t3/lwk", read_data, 32'hDE55BEEF);
    // Misaligned store and load in one cycle: single pulse, no write.
    op(1'b1, 32'h6, 2'd2, 32'h12345678, 1'b1, 32'h3, 2'd1, 1'b0, "t4/mis");
    chk("t4/rdk", read_data, 32'h0);
    chk("t4/aek", 32'(align_err), 32'h1);
    op(1'b0, 32'h0, 2'd0, 32'h0, 1'b0, 32'h0, 2'd0, 1'b0, "t4/idle");
    load(32'h4, 2'd2, 1'b0, "t4/lw");
    chk("t4/lwk", read_data, 32'h0);
    // Same-word store and load.
    store(32'h20, 2'd2, 32'hAAAAAAAA, "t5/init");
    op(1'b1, 32'h20, 2'd2, 32'h11223344, 1'b1, 32'h20, 2'd2, 1'b0, "t5/both");
`ifdef DMEM_FWD_EN
    chk("t5/fwdk", read_data, 32'h11223344);
`else
    chk("t5/oldk", read_data, 32'hAAAAAAAA);
`endif
    load(32'h20, 2'd2, 1'b0, "t5/after");
    chk("t5/afterk", read_data, 32'h11223344);
    // Randomized traffic, biased towards aligned and same-word accesses.
    for (int t = 0; t < 400; t++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      ws = 2'($urandom_range(0, 3));
      rs = 2'($urandom_range(0, 3));
      wa = 32'($urandom_range(0, 63) * 4);
      wa = wa + (($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3)) :
                 ws == 2'd0 ? 32'($urandom_range(0, 3)) : ws == 2'd1 ? 32'(2 * $urandom_range(0, 1)) : 32'h0);
      ra = ($urandom_range(0, 2) == 0) ? (wa & 32'hFFFFFFFC) : 32'($urandom_range(0, 63) * 4);
      ra = ra + (($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3)) :
                 rs == 2'd0 ? 32'($urandom_range(0, 3)) : rs == 2'd1 ? 32'(2 * $urandom_range(0, 1)) : 32'h0);
      op(we, wa, ws, $urandom, re, ra, rs, sg, $sformatf("rnd%0d", t));
    end
    // Reset in the middle of the clear sequence restarts it.
    reset_n = 1'b0;
    #1;
    chk("t6/rst_ready", 32'(ready), 32'h0);
    chk("t6/rst_rd", read_data, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t6/mid_ready", 32'(ready), 32'h0);
    reset_n = 1'b0;
    #2;
    chk("t6/re_ready", 32'(ready), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    n = 0;
    while (!ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t6/clr_cycles", 32'(n), 32'd16);
    for (int i = 0; i < 64; i++) mb[i] = 8'h0;
    exp_rd = 32'h0;
    load(32'h24, 2'd2, 1'b0, "t6/cleared");
    chk("t6/clearedk", read_data, 32'h0);
    store(32'h0, 2'd2, 32'hCAFEF00D, "t6/sw");
    load(32'h40, 2'd2, 1'b0, "t6/alias");
    chk("t6/aliask", read_data, 32'hCAFEF00D);
    store(32'h44, 2'd1, 32'h0000BEEF, "t6/sh");
    load(32'h4, 2'd1, 1'b1, "t6/alias2");
    chk("t6/alias2k", read_data, 32'hFFFFBEEF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
